jtopl_acc_sched: RTL and testbench

- Slot sequencer and output buffer for the single-accumulator mixer.
- Walks the 18 operator slots of an OPL frame in step with `cenop`.
- Drives the accumulator's `zero`/`sum_en` controls from per-channel connection and mute configuration, delayed to match operator pipeline latency.
- Captures each finished frame sum and offers it downstream on a valid/ready handshake with overrun detection.

---
 rtl/jtopl_acc_pkg.sv | 17 +
 rtl/jtopl_acc_dly.sv | 22 ++
 rtl/jtopl_acc_sched.sv | 93 +++++++++
 tb/tb_jtopl_acc_sched.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/jtopl_acc_pkg.sv
// jtopl_acc_pkg: shared constants, control bundle and slot decode for the accumulator scheduler
package jtopl_acc_pkg;
  localparam int NSLOTS = 18;
  localparam int NCH = 9;
  localparam int OP_LAT_MIN = 0;
  localparam int OP_LAT_MAX = 7;
  typedef struct packed {
    logic zero;
    logic sum_en;
  } acc_ctl_t;
  function automatic logic [3:0] slot_ch(input logic [4:0] s);
    return 4'(5'd3 * (s / 5'd6) + s % 5'd3);
  endfunction
  function automatic logic slot_op2(input logic [4:0] s);
    return (s % 5'd6) >= 5'd3;
  endfunction
endpackage

// File: rtl/jtopl_acc_dly.sv
// jtopl_acc_dly: enable-gated shift register with synchronous clear
module jtopl_acc_dly #(
  parameter int W = 2,
  parameter int DEPTH = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] sr_q [DEPTH];
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) sr_q[i] <= '0;
    end else if (en) begin
      sr_q[0] <= d;
      for (int i = 1; i < DEPTH; i++) sr_q[i] <= sr_q[i-1];
    end
  end
  assign q = sr_q[DEPTH-1];
endmodule

// File: rtl/jtopl_acc_sched.sv
// jtopl_acc_sched: slot sequencer and frame sample buffer for the single accumulator mixer
// Optional rhythm override of channels 7/8 is built with JTOPL_ACC_RHYTHM_EN.
module jtopl_acc_sched
  import jtopl_acc_pkg::*;
#(
  parameter int OP_LAT = 2,
  parameter int SNDW = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cenop,
  input  logic            cfg_we,
  input  logic [3:0]      cfg_ch,
  input  logic            cfg_con,
  input  logic            cfg_mute,
  input  logic            rhythm,
  output logic            zero,
  output logic            sum_en,
  output logic [4:0]      slot,
  input  logic [SNDW-1:0] snd_in,
  output logic [SNDW-1:0] smp,
  output logic            smp_valid,
  input  logic            smp_ready,
  output logic            overrun,
  input  logic            ovr_clr
);
  localparam int DEPTH = 1 + ((OP_LAT > OP_LAT_MAX) ? OP_LAT_MAX : OP_LAT);
  logic [4:0] slot_q, slot_d;
  logic [NCH-1:0] con_q, mute_q;
  logic [3:0] ch;
  logic op2, s_raw;
  acc_ctl_t raw, dly;
  logic frame_seen_q, frame_seen_d, cap_pend_q, cap_pend_d;
  logic [SNDW-1:0] smp_q, smp_d;
  logic smp_valid_q, smp_valid_d, overrun_q, overrun_d;
  always_comb begin
    slot_d = !cenop ? slot_q : (slot_q == 5'(NSLOTS - 1)) ? 5'd0 : slot_q + 5'd1;
    ch = slot_ch(slot_q);
    op2 = slot_op2(slot_q);
`ifdef JTOPL_ACC_RHYTHM_EN
    s_raw = !mute_q[ch] && ((rhythm && ch >= 4'd7) || op2 || con_q[ch]);
`else
    s_raw = !mute_q[ch] && (op2 || con_q[ch]);
`endif
    raw = '{zero: slot_q == 5'd0, sum_en: s_raw};
    // the zero pulse right after reset only opens the first frame; nothing is captured from it
    frame_seen_d = frame_seen_q | (cenop & zero);
    cap_pend_d = cenop & zero & frame_seen_q;
    smp_d = cap_pend_q ? snd_in : smp_q;
    smp_valid_d = cap_pend_q | (smp_valid_q & !smp_ready);
    overrun_d = (cap_pend_q & smp_valid_q & !smp_ready) | (overrun_q & !ovr_clr);
  end
`ifndef JTOPL_ACC_RHYTHM_EN
  logic unused_rhythm;
  assign unused_rhythm = rhythm;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_q <= '0;
      con_q <= '0;
      mute_q <= '0;
      frame_seen_q <= 1'b0;
      cap_pend_q <= 1'b0;
      smp_q <= '0;
      smp_valid_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      slot_q <= slot_d;
      if (cfg_we && cfg_ch < 4'(NCH)) begin
        con_q[cfg_ch] <= cfg_con;
        mute_q[cfg_ch] <= cfg_mute;
      end
      frame_seen_q <= frame_seen_d;
      cap_pend_q <= cap_pend_d;
      smp_q <= smp_d;
      smp_valid_q <= smp_valid_d;
      overrun_q <= overrun_d;
    end
  end
  jtopl_acc_dly #(.W($bits(acc_ctl_t)), .DEPTH(DEPTH)) u_dly (
    .clk(clk),
    .rst(rst),
    .en (cenop),
    .d  (raw),
    .q  (dly)
  );
  assign zero = dly.zero;
  assign sum_en = dly.sum_en;
  assign slot = slot_q;
  assign smp = smp_q;
  assign smp_valid = smp_valid_q;
  assign overrun = overrun_q;
endmodule

// File: tb/tb_jtopl_acc_sched.sv
// tb_jtopl_acc_sched: directed table-driven checks of slot decode, delay, capture and handshake
module tb_jtopl_acc_sched;
  localparam int SNDW = 16;
`ifdef JTOPL_ACC_RHYTHM_EN
  localparam logic RHY = 1'b1;
`else
  localparam logic RHY = 1'b0;
`endif
  logic clk = 1'b0, rst, cenop, cfg_we, cfg_con, cfg_mute, rhythm;
  logic [3:0] cfg_ch;
  logic zero, sum_en, smp_valid, smp_ready, overrun, ovr_clr;
  logic [4:0] slot;
  logic [SNDW-1:0] snd_in, smp;
  typedef struct {
    logic [4:0] slot;
    logic zero;
    logic sen_def;
    logic sen_cfg;
  } vec_t;
  vec_t tbl [18];
  int n_tests = 0, n_fail = 0;
  int pulses;
  always #5 clk = ~clk;
  jtopl_acc_sched #(.OP_LAT(2), .SNDW(SNDW)) dut (
    .clk(clk), .rst(rst), .cenop(cenop), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_con(cfg_con), .cfg_mute(cfg_mute), .rhythm(rhythm), .zero(zero),
    .sum_en(sum_en), .slot(slot), .snd_in(snd_in), .smp(smp),
    .smp_valid(smp_valid), .smp_ready(smp_ready), .overrun(overrun), .ovr_clr(ovr_clr)
  );
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic tick(input logic c);
    cenop = c;
    @(posedge clk);
    #1;
    cenop = 1'b0;
  endtask
  task automatic cen_step(input int n);
    for (int i = 0; i < n; i++) begin
      tick(1'b1);
      tick(1'b0);
    end
  endtask
  task automatic cfg(input logic [3:0] c, input logic con, input logic mute);
    cfg_we = 1'b1; cfg_ch = c; cfg_con = con; cfg_mute = mute;
    tick(1'b0);
    cfg_we = 1'b0;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    tick(1'b0);
    rst = 1'b0;
  endtask
  initial begin
    // outputs seen with slot=s reflect the raw decode of slot s-3 (OP_LAT=2)
    tbl[0]  = '{5'd0,  1'b0, 1'b1, 1'b1}; tbl[1]  = '{5'd1,  1'b0, 1'b1, 1'b1};
    tbl[2]  = '{5'd2,  1'b0, 1'b1, 1'b1}; tbl[3]  = '{5'd3,  1'b1, 1'b0, 1'b1};
    tbl[4]  = '{5'd4,  1'b0, 1'b0, 1'b0}; tbl[5]  = '{5'd5,  1'b0, 1'b0, 1'b0};
    tbl[6]  = '{5'd6,  1'b0, 1'b1, 1'b1}; tbl[7]  = '{5'd7,  1'b0, 1'b1, 1'b1};
    tbl[8]  = '{5'd8,  1'b0, 1'b1, 1'b1}; tbl[9]  = '{5'd9,  1'b0, 1'b0, 1'b0};
    tbl[10] = '{5'd10, 1'b0, 1'b0, 1'b0}; tbl[11] = '{5'd11, 1'b0, 1'b0, 1'b0};
    tbl[12] = '{5'd12, 1'b0, 1'b1, 1'b1}; tbl[13] = '{5'd13, 1'b0, 1'b1, 1'b0};
    tbl[14] = '{5'd14, 1'b0, 1'b1, 1'b1}; tbl[15] = '{5'd15, 1'b0, 1'b0, 1'b0};
    tbl[16] = '{5'd16, 1'b0, 1'b0, 1'b0}; tbl[17] = '{5'd17, 1'b0, 1'b0, 1'b0};
    cenop = 0; cfg_we = 0; cfg_ch = 0; cfg_con = 0; cfg_mute = 0; rhythm = 0;
    snd_in = 0; smp_ready = 1; ovr_clr = 0;
    rst = 1'b1;
    tick(1'b0);
    do_reset();
    check("rst_slot", slot, 0); check("rst_zero", zero, 0); check("rst_sen", sum_en, 0);
    check("rst_smp", smp, 0); check("rst_valid", smp_valid, 0); check("rst_ovr", overrun, 0);
    pulses = 0;
    for (int k = 1; k <= 36; k++) begin
      cen_step(1);
      check($sformatf("a_slot@%0d", k), slot, tbl[k % 18].slot);
      check($sformatf("a_zero@%0d", k), zero, k < 3 ? 1'b0 : tbl[k % 18].zero);
      check($sformatf("a_sen@%0d", k), sum_en, k < 3 ? 1'b0 : tbl[k % 18].sen_def);
      if (k > 18) pulses += int'(sum_en);
    end
    check("a_pulses", pulses, 9);
    for (int k = 0; k < 3; k++) tick(1'b0);
    check("hold_slot", slot, 0); check("hold_sen", sum_en, 1);
    cfg(4'd0, 1'b1, 1'b0);
    cfg(4'd4, 1'b0, 1'b1);
    cfg(4'd9, 1'b1, 1'b1);
    cen_step(18);
    for (int k = 1; k <= 18; k++) begin
      cen_step(1);
      check($sformatf("b_zero@%0d", k), zero, tbl[k % 18].zero);
      check($sformatf("b_sen@%0d", k), sum_en, tbl[k % 18].sen_cfg);
    end
    do_reset();
    rhythm = 1'b1;
    cen_step(18);
    for (int k = 1; k <= 18; k++) begin
      cen_step(1);
      if (k == 3) check("c_sen_s3", sum_en, 0);
      if (k == 15) check("c_sen_ch6", sum_en, 0);
      if (k == 16) check("c_sen_ch7", sum_en, RHY);
      if (k == 17) check("c_sen_ch8", sum_en, RHY);
    end
    rhythm = 1'b0;
    do_reset();
    snd_in = 16'hdead; smp_ready = 1'b1;
    cen_step(4);
    check("d_first_zero_valid", smp_valid, 0); check("d_first_zero_smp", smp, 0);
    snd_in = 16'h1234;
    cen_step(18);
    check("d_cap_valid", smp_valid, 1); check("d_cap_smp", smp, 16'h1234); check("d_cap_ovr", overrun, 0);
    tick(1'b0);
    check("d_taken_valid", smp_valid, 0);
    smp_ready = 1'b0; snd_in = 16'h0001;
    cen_step(18);
    check("d_c1_smp", smp, 1); check("d_c1_valid", smp_valid, 1); check("d_c1_ovr", overrun, 0);
    snd_in = 16'h0002;
    cen_step(18);
    check("d_c2_smp", smp, 2); check("d_c2_valid", smp_valid, 1); check("d_c2_ovr", overrun, 1);
    ovr_clr = 1'b1;
    tick(1'b0);
    ovr_clr = 1'b0;
    check("d_clr_ovr", overrun, 0); check("d_clr_valid", smp_valid, 1);
    snd_in = 16'h0003;
    cen_step(17);
    tick(1'b1);
    smp_ready = 1'b1;
    tick(1'b0);
    smp_ready = 1'b0;
    check("d_coin_smp", smp, 3); check("d_coin_valid", smp_valid, 1); check("d_coin_ovr", overrun, 0);
    cen_step(5);
    check("e_pre_slot", slot, 9); check("e_pre_valid", smp_valid, 1);
    do_reset();
    check("e_slot", slot, 0); check("e_valid", smp_valid, 0); check("e_zero", zero, 0);
    check("e_sen", sum_en, 0); check("e_smp", smp, 0);
    cen_step(2);
    check("e_zero_c2", zero, 0);
    cen_step(1);
    check("e_zero_c3", zero, 1); check("e_slot_c3", slot, 3);
    cen_step(1);
    check("e_nocap_valid", smp_valid, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
